// File: rtl/pipelined_parallel_adder.sv
// Ripple-carry adder split into STAGES registered slices with valid/ready flow control and bubble collapsing.
// Optional saturation of the signed result is enabled by defining PIPELINED_PARALLEL_ADDER_SAT_EN.
module pipelined_parallel_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             ic,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             oc,
  output logic             ovf
);
  localparam int W = WIDTH / STAGES;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SW = (k + 1) * W;

    logic          valid_r;
    logic          carry_r;
    logic [SW-1:0] sum_r;
    logic          ready_s;
    logic          take_s;
    logic          load_s;
    logic          cin_s;
    logic [W-1:0]  a_s;
    logic [W-1:0]  b_s;
    logic [W:0]    slice_s;
    logic [SW-1:0] sum_s;
    logic [SW-1:0] store_s;

    // Stage 0 reads the ports; later stages read the remaining operand bits of the previous stage.
    if (k == 0) begin : g_src
      assign a_s    = in1[W-1:0];
      assign b_s    = in2[W-1:0];
      assign cin_s  = ic;
      assign take_s = in_valid;
      assign sum_s  = slice_s[W-1:0];
    end else begin : g_src
      assign a_s    = g_stage[k-1].g_rem.a_rem_r[W-1:0];
      assign b_s    = g_stage[k-1].g_rem.b_rem_r[W-1:0];
      assign cin_s  = g_stage[k-1].carry_r;
      assign take_s = g_stage[k-1].valid_r;
      assign sum_s  = {slice_s[W-1:0], g_stage[k-1].sum_r};
    end

    // A stage can take new data when empty or when its content moves on this cycle.
    if (k == STAGES - 1) begin : g_rdy
      assign ready_s = !valid_r || out_ready;
    end else begin : g_rdy
      assign ready_s = !valid_r || g_stage[k+1].ready_s;
    end

    assign slice_s = {1'b0, a_s} + {1'b0, b_s} + {{W{1'b0}}, cin_s};
    assign load_s  = ready_s && take_s;

    if (k < STAGES - 1) begin : g_rem
      localparam int RW = WIDTH - SW;
      logic [RW-1:0] a_rem_r;
      logic [RW-1:0] b_rem_r;
      logic [RW-1:0] a_rem_s;
      logic [RW-1:0] b_rem_s;

      if (k == 0) begin : g_rsrc
        assign a_rem_s = in1[WIDTH-1:W];
        assign b_rem_s = in2[WIDTH-1:W];
      end else begin : g_rsrc
        assign a_rem_s = g_stage[k-1].g_rem.a_rem_r[RW+W-1:W];
        assign b_rem_s = g_stage[k-1].g_rem.b_rem_r[RW+W-1:W];
      end

      // Operand bits still to be added travel with the operation.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_rem_r <= '0;
          b_rem_r <= '0;
        end else if (load_s) begin
          a_rem_r <= a_rem_s;
          b_rem_r <= b_rem_s;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic cin_msb_s;
      logic ovf_s;
      logic ovf_r;

      // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
      assign cin_msb_s = a_s[W-1] ^ b_s[W-1] ^ slice_s[W-1];
      assign ovf_s     = cin_msb_s ^ slice_s[W];

`ifdef PIPELINED_PARALLEL_ADDER_SAT_EN
      // Clamp toward the sign of in1 when the signed result overflowed.
      always_comb begin
        if (ovf_s) begin
          if (a_s[W-1]) begin
            store_s = {1'b1, {(WIDTH-1){1'b0}}};
          end else begin
            store_s = {1'b0, {(WIDTH-1){1'b1}}};
          end
        end else begin
          store_s = sum_s;
        end
      end
`else
      assign store_s = sum_s;
`endif

      // Overflow flag registered alongside the final sum.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (load_s) begin
          ovf_r <= ovf_s;
        end
      end
    end else begin : g_mid
      assign store_s = sum_s;
    end

    // Stage valid bit, slice carry and accumulated sum bits.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_r <= 1'b0;
        carry_r <= 1'b0;
        sum_r   <= '0;
      end else if (load_s) begin
        valid_r <= 1'b1;
        carry_r <= slice_s[W];
        sum_r   <= store_s;
      end else if (ready_s) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign in_ready  = g_stage[0].ready_s;
  assign out_valid = g_stage[STAGES-1].valid_r;
  assign out       = g_stage[STAGES-1].sum_r;
  assign oc        = g_stage[STAGES-1].carry_r;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_r;

endmodule

// File: tb/tb_pipelined_parallel_adder.sv
// Directed self-checking bench for pipelined_parallel_adder (WIDTH=16, STAGES=4).
// Expected sums follow PIPELINED_PARALLEL_ADDER_SAT_EN when it is defined.
module tb_pipelined_parallel_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        ic;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        oc;
  logic        ovf;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pipelined_parallel_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .ic(ic), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .oc(oc), .ovf(ovf)
  );

  // Issue one operation into an empty pipeline and capture its result and latency.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        output logic [15:0] o, output logic o_c, output logic o_v, output int lat);
    @(negedge clk);
    in1 = a; in2 = b; ic = c; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1; o = 16'h0000; o_c = 1'b0; o_v = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        o = out; o_c = oc; o_v = ovf; lat = n;
        break;
      end
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in1 = 16'h0000; in2 = 16'h0000; ic = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++; if (out !== 16'h0000) $display("FAIL reset_out: got %h want 0000", out); else pass_cnt++;
    total_cnt++; if (oc !== 1'b0) $display("FAIL reset_oc: got %b want 0", oc); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_latency();
    logic [15:0] o; logic o_c, o_v; int lat;
    run_op(16'hFFFF, 16'h0001, 1'b0, o, o_c, o_v, lat);
    total_cnt++; if (o !== 16'h0000) $display("FAIL lat_out: got %h want 0000", o); else pass_cnt++;
    total_cnt++; if (o_c !== 1'b1) $display("FAIL lat_oc: got %b want 1", o_c); else pass_cnt++;
    total_cnt++; if (o_v !== 1'b0) $display("FAIL lat_ovf: got %b want 0", o_v); else pass_cnt++;
    total_cnt++; if (lat !== 4) $display("FAIL lat_cycles: got %0d want 4", lat); else pass_cnt++;
  endtask

  task automatic test_carry_chain();
    logic [15:0] o; logic o_c, o_v; int lat;
    run_op(16'h00FF, 16'h0000, 1'b1, o, o_c, o_v, lat);
    total_cnt++; if (o !== 16'h0100) $display("FAIL carry_00ff_out: got %h want 0100", o); else pass_cnt++;
    total_cnt++; if (o_c !== 1'b0) $display("FAIL carry_00ff_oc: got %b want 0", o_c); else pass_cnt++;
    run_op(16'h0FFF, 16'h0000, 1'b1, o, o_c, o_v, lat);
    total_cnt++; if (o !== 16'h1000) $display("FAIL carry_0fff_out: got %h want 1000", o); else pass_cnt++;
    total_cnt++; if (o_c !== 1'b0) $display("FAIL carry_0fff_oc: got %b want 0", o_c); else pass_cnt++;
    run_op(16'hFFFF, 16'hFFFF, 1'b1, o, o_c, o_v, lat);
    total_cnt++; if ({o_c, o_v, o} !== {1'b1, 1'b0, 16'hFFFF}) $display("FAIL carry_ffff_ffff: got oc=%b ovf=%b out=%h want oc=1 ovf=0 out=ffff", o_c, o_v, o); else pass_cnt++;
    run_op(16'h1234, 16'h4321, 1'b0, o, o_c, o_v, lat);
    total_cnt++; if ({o_c, o_v, o} !== {1'b0, 1'b0, 16'h5555}) $display("FAIL plain_add: got oc=%b ovf=%b out=%h want oc=0 ovf=0 out=5555", o_c, o_v, o); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [15:0] o; logic o_c, o_v; int lat;
    logic [15:0] exp_pos, exp_neg;
`ifdef PIPELINED_PARALLEL_ADDER_SAT_EN
    exp_pos = 16'h7FFF; exp_neg = 16'h8000;
`else
    exp_pos = 16'h8000; exp_neg = 16'h7FFF;
`endif
    run_op(16'h7FFF, 16'h0001, 1'b0, o, o_c, o_v, lat);
    total_cnt++; if (o !== exp_pos) $display("FAIL ovf_pos_out: got %h want %h", o, exp_pos); else pass_cnt++;
    total_cnt++; if ({o_c, o_v} !== 2'b01) $display("FAIL ovf_pos_flags: got oc=%b ovf=%b want oc=0 ovf=1", o_c, o_v); else pass_cnt++;
    run_op(16'h8000, 16'hFFFF, 1'b0, o, o_c, o_v, lat);
    total_cnt++; if (o !== exp_neg) $display("FAIL ovf_neg_out: got %h want %h", o, exp_neg); else pass_cnt++;
    total_cnt++; if ({o_c, o_v} !== 2'b11) $display("FAIL ovf_neg_flags: got oc=%b ovf=%b want oc=1 ovf=1", o_c, o_v); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_out [8];
    logic        exp_oc  [8];
    int issued, recv, occ;
    logic blocked_seen;
    exp_out = '{16'h9101, 16'hA213, 16'hB323, 16'hC435, 16'hD545, 16'hE657, 16'hF767, 16'h0879};
    exp_oc  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    issued = 0; recv = 0; blocked_seen = 1'b0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 2 && cyc < 8);
      in_valid  = (issued < 8);
      in1       = 16'(16'h1111 * issued);
      in2       = 16'h9101;
      ic        = issued[0];
      #1;
      occ = issued - recv;
      total_cnt++;
      if (in_ready !== ((occ < 4) || out_ready))
        $display("FAIL b2b_in_ready cyc %0d: got %b want %b", cyc, in_ready, ((occ < 4) || out_ready));
      else pass_cnt++;
      if (occ == 4 && !in_ready) blocked_seen = 1'b1;
      if (out_valid && out_ready) begin
        total_cnt++;
        if ({oc, out} !== {exp_oc[recv], exp_out[recv]})
          $display("FAIL b2b_result %0d: got oc=%b out=%h want oc=%b out=%h", recv, oc, out, exp_oc[recv], exp_out[recv]);
        else pass_cnt++;
        recv++;
      end
      if (in_valid && in_ready) issued++;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    total_cnt++; if (recv !== 8) $display("FAIL b2b_count: got %0d want 8", recv); else pass_cnt++;
    total_cnt++; if (blocked_seen !== 1'b1) $display("FAIL b2b_backpressure: got %b want 1", blocked_seen); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in1 = 16'(16'h0110 + k); in2 = 16'h0000; ic = 1'b0; in_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total_cnt++; if ({out_valid, in_ready} !== 2'b10) $display("FAIL sim_full: got out_valid=%b in_ready=%b want 1 0", out_valid, in_ready); else pass_cnt++;
    in1 = 16'h0114; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    total_cnt++; if ({out_valid, in_ready} !== 2'b11) $display("FAIL sim_both: got out_valid=%b in_ready=%b want 1 1", out_valid, in_ready); else pass_cnt++;
    total_cnt++; if (out !== 16'h0110) $display("FAIL sim_first_out: got %h want 0110", out); else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    total_cnt++; if ({out_valid, in_ready} !== 2'b10) $display("FAIL sim_still_full: got out_valid=%b in_ready=%b want 1 0", out_valid, in_ready); else pass_cnt++;
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      total_cnt++;
      if (!(out_valid === 1'b1 && out === 16'(16'h0110 + k)))
        $display("FAIL sim_drain %0d: got valid=%b out=%h want valid=1 out=%h", k, out_valid, out, 16'(16'h0110 + k));
      else pass_cnt++;
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL sim_empty: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int stale;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in1 = 16'(16'h2000 + k); in2 = 16'h0001; ic = 1'b0; in_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in1 = 16'hAAAA; in2 = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    #1;
    total_cnt++; if ({out_valid, out} !== {1'b0, 16'h0000}) $display("FAIL rstmid_during: got valid=%b out=%h want valid=0 out=0000", out_valid, out); else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total_cnt++; if ({out, oc, ovf} !== {16'h0000, 1'b0, 1'b0}) $display("FAIL rstmid_data: got out=%h oc=%b ovf=%b want 0000 0 0", out, oc, ovf); else pass_cnt++;
    total_cnt++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL rstmid_hs: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); else pass_cnt++;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    total_cnt++; if (stale !== 0) $display("FAIL rstmid_stale: got %0d results want 0", stale); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_carry_chain();
    test_overflow();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipelined_parallel_adder.md
PIPELINED_PARALLEL_ADDER -- requirements
Module: pipelined_parallel_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4, meaning pipeline depth in slices; WIDTH SHALL be an integer multiple of STAGES.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning operands are valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the adder accepts operands this cycle.
REQ-007 SHALL have port in1, input, WIDTH bits, meaning operand A.
REQ-008 SHALL have port in2, input, WIDTH bits, meaning operand B.
REQ-009 SHALL have port ic, input, 1 bit, meaning carry-in.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning the result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-012 SHALL have port out, output, WIDTH bits, meaning the sum.
REQ-013 SHALL have port oc, output, 1 bit, meaning carry-out of the MSB.
REQ-014 SHALL have port ovf, output, 1 bit, meaning two's-complement signed overflow.

Function
REQ-015 SHALL split the add into STAGES slices of W=WIDTH/STAGES bits; stage k adds bits [k*W +: W] plus carry registered from stage k-1; stage 0 uses ic.
REQ-016 SHALL carry unconsumed operand bits and finished sum bits forward in per-stage registers; no combinational carry path longer than W bits.
REQ-017 SHALL hold one valid bit per stage; a transfer occurs at input when in_valid && in_ready, at output when out_valid && out_ready.
REQ-018 SHALL advance stage k when stage k+1 is empty or advancing in the same cycle (bubble collapsing); last stage advances on out_ready.
REQ-019 SHALL drive in_ready = stage 0 empty or stage 0 advancing; combinational from out_ready allowed, no path from in_valid to in_ready.
REQ-020 SHALL give latency exactly STAGES cycles from input transfer to out_valid when never stalled; throughput one result per cycle.
REQ-021 SHALL hold out, oc, ovf, out_valid stable while out_valid && !out_ready.
REQ-022 SHALL compute {oc,out} = in1 + in2 + ic modulo 2^(WIDTH+1); ovf = carry into MSB XOR carry out of MSB.
REQ-023 SHALL preserve order and never drop or duplicate an accepted operation; pipeline holds at most STAGES operations.
REQ-024 SHALL accept a new operation in the same cycle the full pipeline delivers a result (simultaneous in/out transfer).

Reset
REQ-025 SHALL on rst clear every stage valid bit and data register; out=0, oc=0, ovf=0, out_valid=0 from the next edge.
REQ-026 SHALL discard in-flight operations on rst mid-operation; in_ready=1 on the first cycle after rst deasserts.
REQ-027 SHALL ignore in_valid during rst.

Configuration
REQ-028 SHALL, with macro PIPELINED_PARALLEL_ADDER_SAT_EN defined, replace out by 2^(WIDTH-1)-1 when ovf and in1 MSB=0, by 2^(WIDTH-1) when ovf and in1 MSB=1; oc and ovf unchanged.
REQ-029 SHALL, without PIPELINED_PARALLEL_ADDER_SAT_EN, output the wrapped modular sum; no saturation logic present.

Verification (WIDTH=16, STAGES=4)
REQ-030 SHALL cover: rst held 2 cycles mid-stream -> out=0x0000, oc=0, ovf=0, out_valid=0, in_ready=1 after release, no stale result emerges.
REQ-031 SHALL cover: 0xFFFF+0x0001, ic=0, out_ready=1 -> out=0x0000, oc=1, ovf=0, out_valid exactly 4 cycles after acceptance.
REQ-032 SHALL cover: 0x00FF+0x0000, ic=1 -> out=0x0100, oc=0; 0x0FFF+0x0000, ic=1 -> 0x1000 (carry crosses slice boundaries).
REQ-033 SHALL cover: 0x7FFF+0x0001 -> ovf=1, out=0x8000 without macro, 0x7FFF with macro; 0x8000+0xFFFF -> ovf=1, oc=1, out=0x7FFF without macro, 0x8000 with macro.
REQ-034 SHALL cover: 8 back-to-back ops, out_ready low from cycle 2 for 6 cycles -> in_ready low once 4 ops held, all 8 results delivered in order with correct sums.
REQ-035 SHALL cover: full pipeline, in_valid=1 and out_ready=1 same cycle -> one result out and one op in that cycle, occupancy stays 4.
